// File: rtl/apb_ucpd_bmc_tx.sv
// rtl/apb_ucpd_bmc_tx.sv - USB-PD BMC transmitter: preamble, SOP, 4b5b payload, EOP, tail
// A byte holding register feeds a 10-bit shift register; one line edge per half-bit tick.
module apb_ucpd_bmc_tx #(
  parameter int PRE_BITS = 64
) (
  input  logic        ic_clk,
  input  logic        ic_rst,
  input  logic        hbit_tick,
  input  logic        start,
  input  logic        abort,
  input  logic [19:0] sop_ordset,
  input  logic [7:0]  byte_data,
  input  logic        byte_vld,
  input  logic        byte_last,
  output logic        byte_rdy,
  output logic        cc_out,
  output logic        cc_oen,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SOP, DATA, EOP, TAIL} state_t;

  localparam logic [9:0] EOP_SHIFT = 10'h00D;
  localparam logic [6:0] PRE_LAST  = 7'(PRE_BITS - 1);

  function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
    case (nib)
      4'h0: return 5'h1E;
      4'h1: return 5'h09;
      4'h2: return 5'h14;
      4'h3: return 5'h15;
      4'h4: return 5'h0A;
      4'h5: return 5'h0B;
      4'h6: return 5'h0E;
      4'h7: return 5'h0F;
      4'h8: return 5'h12;
      4'h9: return 5'h13;
      4'hA: return 5'h16;
      4'hB: return 5'h17;
      4'hC: return 5'h1A;
      4'hD: return 5'h1B;
      4'hE: return 5'h1C;
      default: return 5'h1D;
    endcase
  endfunction

  state_t      state_q;
  logic        out_q, oen_q, busy_q, rdy_q, done_q, und_q;
  logic        ph_q, und_seen_q, cur_last_q;
  logic [6:0]  bit_q;
  logic [2:0]  sym_q;
  logic [19:0] sop_q;
  logic [9:0]  sh_q;
  logic [7:0]  hold_q;
  logic        hold_full_q, hold_last_q, last_seen_q;

  logic tick, start_acc, take, bit_end, end_tail, copy_due, do_copy, cur_bit;
  logic busy_d, hold_full_d, last_seen_d, rdy_d;

  // An accepted start leaves the state in IDLE with busy set; the next tick opens the preamble.
  always_comb begin
    tick      = hbit_tick && busy_q && !abort;
    start_acc = start && !busy_q && !abort;
    take      = byte_vld && rdy_q && !abort;
    bit_end   = tick && ph_q && (state_q inside {PRE, SOP, DATA, EOP});
    end_tail  = tick && ph_q && (state_q == TAIL);
    copy_due  = bit_end && (bit_q == 7'd4) &&
                ((state_q == SOP && sym_q == 3'd3) ||
                 (state_q == DATA && sym_q == 3'd1 && !cur_last_q));
    do_copy   = copy_due && hold_full_q;

    cur_bit = 1'b0;
    case (state_q)
      PRE:       cur_bit = bit_q[0];
      SOP:       cur_bit = sop_q[0];
      DATA, EOP: cur_bit = sh_q[0];
      default:   cur_bit = 1'b0;
    endcase

    busy_d = busy_q;
    if (end_tail)  busy_d = 1'b0;
    if (start_acc) busy_d = 1'b1;
    if (abort)     busy_d = 1'b0;

    hold_full_d = hold_full_q;
    if (do_copy)            hold_full_d = 1'b0;
    if (take)               hold_full_d = 1'b1;
    if (start_acc || abort) hold_full_d = 1'b0;

    last_seen_d = last_seen_q | (take & byte_last);
    if (start_acc || abort) last_seen_d = 1'b0;

    rdy_d = busy_d && !hold_full_d && !last_seen_d;
  end

  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      state_q <= IDLE;  out_q <= 1'b0;  oen_q <= 1'b1;  busy_q <= 1'b0;
      rdy_q <= 1'b0;    done_q <= 1'b0; und_q <= 1'b0;  ph_q <= 1'b0;
      und_seen_q <= 1'b0; cur_last_q <= 1'b0; bit_q <= '0; sym_q <= '0;
      sop_q <= '0; sh_q <= '0; hold_q <= '0;
      hold_full_q <= 1'b0; hold_last_q <= 1'b0; last_seen_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
      last_seen_q <= last_seen_d;
      rdy_q       <= rdy_d;
      done_q      <= 1'b0;
      und_q       <= 1'b0;
      if (take) begin
        hold_q      <= byte_data;
        hold_last_q <= byte_last;
      end
      if (abort) begin
        state_q <= IDLE;
        out_q   <= 1'b0;
        oen_q   <= 1'b1;
        ph_q    <= 1'b0;
      end else if (start_acc) begin
        sop_q      <= sop_ordset;
        ph_q       <= 1'b0;
        bit_q      <= '0;
        sym_q      <= '0;
        und_seen_q <= 1'b0;
        cur_last_q <= 1'b0;
      end else if (tick) begin
        case (state_q)
          IDLE: begin
            state_q <= PRE;
            out_q   <= 1'b1;
            oen_q   <= 1'b0;
            ph_q    <= 1'b1;
            bit_q   <= '0;
          end
          TAIL: begin
            if (!ph_q) begin
              out_q <= 1'b0;
              ph_q  <= 1'b1;
            end else begin
              oen_q   <= 1'b1;
              done_q  <= !und_seen_q;
              state_q <= IDLE;
              ph_q    <= 1'b0;
            end
          end
          default: begin
            if (!ph_q) begin
              out_q <= !out_q;
              ph_q  <= 1'b1;
            end else begin
              if (cur_bit) out_q <= !out_q;
              ph_q  <= 1'b0;
              bit_q <= bit_q + 7'd1;
              case (state_q)
                PRE: if (bit_q == PRE_LAST) begin
                  state_q <= SOP;
                  bit_q   <= '0;
                  sym_q   <= '0;
                end
                SOP: begin
                  sop_q <= {1'b0, sop_q[19:1]};
                  if (bit_q == 7'd4) begin
                    bit_q <= '0;
                    sym_q <= sym_q + 3'd1;
                    if (sym_q == 3'd3) begin
                      sym_q <= '0;
                      if (hold_full_q) begin
                        state_q    <= DATA;
                        sh_q       <= {enc4b5b(hold_q[7:4]), enc4b5b(hold_q[3:0])};
                        cur_last_q <= hold_last_q;
                      end else begin
                        state_q    <= TAIL;
                        und_q      <= 1'b1;
                        und_seen_q <= 1'b1;
                      end
                    end
                  end
                end
                DATA: begin
                  sh_q <= {1'b0, sh_q[9:1]};
                  if (bit_q == 7'd4) begin
                    bit_q <= '0;
                    sym_q <= sym_q + 3'd1;
                    if (sym_q == 3'd1) begin
                      sym_q <= '0;
                      if (cur_last_q) begin
                        state_q <= EOP;
                        sh_q    <= EOP_SHIFT;
                      end else if (hold_full_q) begin
                        sh_q       <= {enc4b5b(hold_q[7:4]), enc4b5b(hold_q[3:0])};
                        cur_last_q <= hold_last_q;
                      end else begin
                        state_q    <= TAIL;
                        und_q      <= 1'b1;
                        und_seen_q <= 1'b1;
                      end
                    end
                  end
                end
                EOP: begin
                  sh_q <= {1'b0, sh_q[9:1]};
                  if (bit_q == 7'd4) state_q <= TAIL;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign byte_rdy = rdy_q;
  assign cc_out   = out_q;
  assign cc_oen   = oen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_apb_ucpd_bmc_tx.sv
// tb/tb_apb_ucpd_bmc_tx.sv - self-checking bench for apb_ucpd_bmc_tx
module tb_apb_ucpd_bmc_tx;
  localparam int PRE = 64;

  logic        ic_clk = 1'b0;
  logic        ic_rst, hbit_tick, start, abort, byte_vld, byte_last;
  logic [19:0] sop_ordset;
  logic [7:0]  byte_data;
  logic        byte_rdy, cc_out, cc_oen, busy, done, underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int enc_tbl[16]  = '{'h1E, 'h09, 'h14, 'h15, 'h0A, 'h0B, 'h0E, 'h0F,
                       'h12, 'h13, 'h16, 'h17, 'h1A, 'h1B, 'h1C, 'h1D};
  int exp_syms[7]  = '{'h18, 'h18, 'h18, 'h11, 'h0B, 'h16, 'h0D};
  int eop_code     = 'h0D;

  typedef struct {
    logic [19:0] sop;
    int          nbytes;
    logic [31:0] bytes;
    bit          has_last;
    int          delay;
    int          gap;
    bit          coincide;
    bit          restart;
    int          exp_ticks;
    int          exp_done;
    int          exp_under;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  always #5 ic_clk = ~ic_clk;

  apb_ucpd_bmc_tx #(.PRE_BITS(PRE)) dut (
    .ic_clk(ic_clk), .ic_rst(ic_rst), .hbit_tick(hbit_tick), .start(start),
    .abort(abort), .sop_ordset(sop_ordset), .byte_data(byte_data),
    .byte_vld(byte_vld), .byte_last(byte_last), .byte_rdy(byte_rdy),
    .cc_out(cc_out), .cc_oen(cc_oen), .busy(busy), .done(done), .underrun(underrun)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Expected line as {cc_out, cc_oen} after each counted tick, built from the bit stream.
  task automatic model(input vec_t v);
    int bits[$];
    int lvl;
    int code;
    logic [7:0] bv;
    exp_q.delete();
    for (int i = 0; i < PRE; i++) bits.push_back(i % 2);
    for (int k = 0; k < 4; k++) begin
      code = int'((v.sop >> (5 * k)) & 20'h1F);
      for (int b = 0; b < 5; b++) bits.push_back((code >> b) & 1);
    end
    for (int n = 0; n < v.nbytes; n++) begin
      bv = v.bytes[8*n +: 8];
      for (int h = 0; h < 2; h++) begin
        code = enc_tbl[h == 0 ? int'(bv[3:0]) : int'(bv[7:4])];
        for (int b = 0; b < 5; b++) bits.push_back((code >> b) & 1);
      end
    end
    if (v.has_last)
      for (int b = 0; b < 5; b++) bits.push_back((eop_code >> b) & 1);
    lvl = 0;
    foreach (bits[i]) begin
      lvl ^= 1;
      exp_q.push_back({lvl[0], 1'b0});
      if (bits[i] != 0) lvl ^= 1;
      exp_q.push_back({lvl[0], 1'b0});
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int  bi = 0;
    int  wait_cnt = 0;
    int  dones = 0;
    int  unders = 0;
    int  mis = -1;
    bit  ended = 0;
    bit  taken, tk;
    got_q.delete();
    model(v);
    hbit_tick  = v.coincide;
    start      = 1'b1;
    sop_ordset = v.sop;
    @(posedge ic_clk); #1;
    start = 1'b0; hbit_tick = 1'b0;
    for (int cyc = 0; cyc < 6000 && !ended; cyc++) begin
      tk        = (cyc % v.gap) == (v.gap - 1);
      hbit_tick = tk;
      start     = v.restart && cyc == 50;
      if (start) sop_ordset = ~v.sop;
      if (bi < v.nbytes && !byte_vld && byte_rdy) begin
        if (wait_cnt >= v.delay) begin
          byte_vld  = 1'b1;
          byte_data = v.bytes[8*bi +: 8];
          byte_last = v.has_last && (bi == v.nbytes - 1);
        end else wait_cnt++;
      end
      taken = byte_vld && byte_rdy;
      @(posedge ic_clk); #1;
      hbit_tick = 1'b0; start = 1'b0;
      if (taken) begin
        bi++; byte_vld = 1'b0; byte_last = 1'b0; wait_cnt = 0;
      end
      if (done) dones++;
      if (underrun) unders++;
      if (tk) got_q.push_back({cc_out, cc_oen});
      if (!busy) ended = 1;
    end
    chk({tag, "_end"}, int'(ended), 1);
    chk({tag, "_ticks"}, got_q.size(), v.exp_ticks);
    for (int i = 0; i < exp_q.size() && mis < 0; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mis = i;
    if (mis < 0 && got_q.size() > exp_q.size()) mis = exp_q.size();
    chk({tag, "_line_first_bad_tick"}, mis, -1);
    chk({tag, "_done"}, dones, v.exp_done);
    chk({tag, "_underrun"}, unders, v.exp_under);
    chk({tag, "_bytes"}, bi, v.nbytes);
  endtask

  initial begin
    vec_t v;
    int   tk_cnt;
    int   sym;
    bit   tk, taken;

    ic_rst = 1'b1; hbit_tick = 1'b0; start = 1'b0; abort = 1'b0;
    sop_ordset = '0; byte_data = '0; byte_vld = 1'b0; byte_last = 1'b0;
    repeat (2) @(posedge ic_clk);
    #1;
    chk("rst_out_oen_busy_rdy_done_und", int'({cc_out, cc_oen, busy, byte_rdy, done, underrun}), 'b010000);
    ic_rst = 1'b0;
    @(posedge ic_clk); #1;

    vecs.push_back('{sop:20'h8E318, nbytes:1, bytes:32'hA5, has_last:1, delay:0, gap:4,
                     coincide:0, restart:0, exp_ticks:200, exp_done:1, exp_under:0});
    vecs.push_back('{sop:20'h8E318, nbytes:2, bytes:32'h3412, has_last:1, delay:40, gap:4,
                     coincide:0, restart:0, exp_ticks:220, exp_done:1, exp_under:0});
    vecs.push_back('{sop:20'h8E318, nbytes:1, bytes:32'h5A, has_last:0, delay:0, gap:3,
                     coincide:0, restart:0, exp_ticks:190, exp_done:0, exp_under:1});
    vecs.push_back('{sop:20'h8E318, nbytes:1, bytes:32'hC3, has_last:1, delay:5, gap:4,
                     coincide:1, restart:1, exp_ticks:200, exp_done:1, exp_under:0});
    vecs.push_back('{sop:20'h1234A, nbytes:3, bytes:32'h00F07E, has_last:1, delay:10, gap:5,
                     coincide:0, restart:0, exp_ticks:240, exp_done:1, exp_under:0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        if (got_q.size() >= 2 * (PRE + 35)) begin
          for (int s = 0; s < 7; s++) begin
            sym = 0;
            for (int b = 0; b < 5; b++) begin
              if (got_q[2*(PRE + 5*s + b)][1] != got_q[2*(PRE + 5*s + b) + 1][1])
                sym |= (1 << b);
            end
            chk($sformatf("vec0_sym%0d", s), sym, exp_syms[s]);
          end
        end else chk("vec0_sym_len", got_q.size(), 2 * (PRE + 35));
      end
      repeat (3) @(posedge ic_clk);
      #1;
    end

    // Abort while the SOP is on the line, then a fresh frame.
    start = 1'b1; sop_ordset = 20'h8E318;
    @(posedge ic_clk); #1;
    start = 1'b0;
    tk_cnt = 0;
    for (int cyc = 0; cyc < 2000 && tk_cnt < 130; cyc++) begin
      tk = (cyc % 4) == 3;
      hbit_tick = tk;
      @(posedge ic_clk); #1;
      hbit_tick = 1'b0;
      if (tk) tk_cnt++;
    end
    chk("abort_reach_sop", tk_cnt, 130);
    abort = 1'b1;
    @(posedge ic_clk); #1;
    abort = 1'b0;
    chk("abort_oen", int'(cc_oen), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_rdy_done", int'({cc_out, byte_rdy, done}), 0);
    run_frame(vecs[0], "after_abort");

    // Asynchronous reset in the middle of DATA.
    start = 1'b1; sop_ordset = 20'h8E318;
    @(posedge ic_clk); #1;
    start = 1'b0; byte_vld = 1'b1; byte_data = 8'h5A; byte_last = 1'b0;
    tk_cnt = 0;
    for (int cyc = 0; cyc < 2000 && tk_cnt < 175; cyc++) begin
      tk = (cyc % 4) == 3;
      hbit_tick = tk;
      taken = byte_vld && byte_rdy;
      @(posedge ic_clk); #1;
      hbit_tick = 1'b0;
      if (taken) byte_vld = 1'b0;
      if (tk) tk_cnt++;
    end
    byte_vld = 1'b0;
    chk("prerst_busy", int'({busy, cc_oen}), 'b10);
    #2 ic_rst = 1'b1;
    #1;
    chk("midrst_out_oen_busy_rdy_done_und", int'({cc_out, cc_oen, busy, byte_rdy, done, underrun}), 'b010000);
    @(posedge ic_clk); #1;
    ic_rst = 1'b0;
    @(posedge ic_clk); #1;
    chk("postrst_out_oen_busy_rdy_done_und", int'({cc_out, cc_oen, busy, byte_rdy, done, underrun}), 'b010000);

    for (int r = 0; r < 6; r++) begin
      v.sop       = 20'($urandom);
      v.nbytes    = $urandom_range(1, 4);
      v.bytes     = $urandom;
      v.has_last  = 1;
      v.delay     = $urandom_range(0, 40);
      v.gap       = $urandom_range(3, 5);
      v.coincide  = 1'($urandom_range(0, 1));
      v.restart   = 1'($urandom_range(0, 1));
      v.exp_ticks = 2 * (PRE + 20 + 10 * v.nbytes + 5) + 2;
      v.exp_done  = 1;
      v.exp_under = 0;
      run_frame(v, $sformatf("rnd%0d", r));
      repeat (2) @(posedge ic_clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
